mux4x1_rr_merge: RTL
====================

// Module: mux4x1_rr_merge
// PURPOSE
//  Merging end of the 1:4 demux path: collects four independent valid/ready input
//  channels into one registered output stream. Round-robin arbitration guarantees
//  fairness; out_sel tags every word with its source channel so a downstream demux4x1
//  can steer responses back. Sits between four producer lanes and a shared sink.
// PARAMETERS
//  DATA_W  8   width of each data word
//  CNT_W   16  width of accepted-transfer counter (wraps)
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  rst_n      in   1       synchronous, active-low reset (sampled on posedge clk)
//  in_valid   in   4       per-channel request; bit k = channel k
//  in_data0   in   DATA_W  channel 0 word (in_data1..in_data3 identical, channels 1..3)
//  in_ready   out  4       per-channel accept; at most one bit high per cycle
//  out_valid  out  1       output register holds a word
//  out_data   out  DATA_W  registered word
//  out_sel    out  2       source channel of out_data
//  out_ready  in   1       sink accepts out_data this cycle
//  xfer_cnt   out  CNT_W   number of completed output transfers
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_sel=0, ptr=0,
//    xfer_cnt=0; in_ready forced to 4'b0000 combinationally while rst_n=0.
//  - load_en = !out_valid || out_ready (output register empty or draining this cycle).
//  - Grant g = first k with in_valid[k]=1 scanning ptr, ptr+1, ... mod 4.
//  - in_ready[g]=1 only when load_en && |in_valid; all other bits 0. Combinational
//    from in_valid, out_valid, out_ready, ptr, rst_n. Input handshake = in_valid[k]&&in_ready[k].
//  - On input handshake: out_data<=in_data_g, out_sel<=g, out_valid<=1, ptr<=(g+1) mod 4.
//  - load_en && no in_valid: out_valid<=0 (if it was 1, word drained); ptr unchanged.
//  - out_valid && !out_ready: out_data, out_sel, out_valid held stable; in_ready=0.
//  - Latency input handshake -> out_valid: 1 cycle. Throughput: 1 word/cycle with
//    out_ready held high (drain and refill in same cycle, no bubble).
//  - xfer_cnt += 1 on out_valid && out_ready; wraps 2^CNT_W-1 -> 0.
//  - ptr wrap: grant to channel 3 sets ptr=0.
//  - Single requester: granted every cycle regardless of ptr (no idle cycle).
//  - Reset mid-operation: held word discarded, no handshake that cycle, ptr returns to 0.
//  - in_data of non-granted channels ignored; requester must hold in_valid/data until accepted.
// STRUCTURE
//  - Shared constants file: NUM_CH=4, SEL_W=2, channel index localparams CH0..CH3.
//  - Sub-module rr_arbiter4: inputs req[3:0], ptr[1:0], en; outputs gnt[3:0]
//    (one-hot), gnt_idx[1:0], any. Pure combinational; ptr register in top.
//  - Top: arbiter, 4:1 data select by gnt_idx, output register, ptr, counter.
// TESTING
//  1. Reset: rst_n=0 two cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0,
//     xfer_cnt=0; first cycle after release grants ch0.
//  2. All request, out_ready=1, data A0/B1/C2/D3 -> out_sel 0,1,2,3,0 on successive
//     cycles, out_data matches, one in_ready bit per cycle, xfer_cnt counts 1..5.
//  3. Backpressure: word 8'h5A from ch2 accepted, out_ready=0 for 3 cycles ->
//     out_data=8'h5A, out_sel=2 stable, in_ready=0; out_ready=1 -> xfer_cnt+1, next load same cycle.
//  4. Sparse: only ch3 valid for 4 cycles, out_ready=1 -> granted every cycle, ptr
//     wraps to 0; then ch1 and ch3 valid -> ch1 granted first.
//  5. Drain to idle: last word consumed with in_valid=0 -> out_valid=0 next cycle.
//  6. Counter wrap (CNT_W=4): 17 transfers -> xfer_cnt=1; mid-stream reset -> out_valid=0, ptr=0.

Source files
------------

// File: rtl/mux4x1_rr_merge_pkg.sv
// Shared constants and small helpers for the 4:1 round-robin merge.
// Channel count, select width and channel indices live here so the
// interface, arbiter and top agree on one definition.
package mux4x1_rr_merge_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [NUM_CH-1:0] ch_mask_t;
    typedef logic [SEL_W-1:0]  ch_idx_t;

    localparam ch_idx_t CH0 = 2'd0;
    localparam ch_idx_t CH1 = 2'd1;
    localparam ch_idx_t CH2 = 2'd2;
    localparam ch_idx_t CH3 = 2'd3;

    // Pointer always moves to the channel after the winner; the 2-bit add
    // wraps channel 3 back to channel 0 for free.
    function automatic ch_idx_t next_ptr(input ch_idx_t gnt_idx);
        return gnt_idx + CH1;
    endfunction

    // One-hot mask for a channel index.
    function automatic ch_mask_t idx_to_mask(input ch_idx_t idx);
        ch_mask_t m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mux4x1_rr_merge_if.sv
// Bundle of the four producer lanes, the shared sink handshake and the
// transfer counter. The slave modport is the merge block's view; the
// master modport is the view of whatever drives the lanes and the sink.
interface mux4x1_rr_merge_if
    import mux4x1_rr_merge_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);

    logic [NUM_CH-1:0] in_valid;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;
    logic [DATA_W-1:0] in_data2;
    logic [DATA_W-1:0] in_data3;
    logic [NUM_CH-1:0] in_ready;

    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;
    logic              out_ready;

    logic [CNT_W-1:0]  xfer_cnt;

    modport slave (
        input  in_valid,
        input  in_data0,
        input  in_data1,
        input  in_data2,
        input  in_data3,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel,
        input  out_ready,
        output xfer_cnt
    );

    modport master (
        output in_valid,
        output in_data0,
        output in_data1,
        output in_data2,
        output in_data3,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel,
        output out_ready,
        input  xfer_cnt
    );

endinterface

// File: rtl/mux4x1_rr_merge_rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational.
// Scans ptr, ptr+1, ... (mod 4) and picks the first requester. The index
// and 'any' are reported regardless of en; the one-hot grant is only
// raised when en allows the winner to be accepted.
module rr_arbiter4
    import mux4x1_rr_merge_pkg::*;
(
    input  ch_mask_t req,
    input  ch_idx_t  ptr,
    input  logic     en,
    output ch_mask_t gnt,
    output ch_idx_t  gnt_idx,
    output logic     any
);

    ch_idx_t scan_idx;

    // Priority scan starting at the pointer; first hit wins.
    always_comb begin
        gnt_idx  = CH0;
        any      = 1'b0;
        scan_idx = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = ptr + ch_idx_t'(i);
            if (!any && req[scan_idx]) begin
                any     = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // Grant is one-hot only when there is a winner and the caller can take it.
    always_comb begin
        gnt = '0;
        if (en && any) begin
            gnt = idx_to_mask(gnt_idx);
        end
    end

endmodule

// File: rtl/mux4x1_rr_merge.sv
// 4:1 round-robin merge of valid/ready lanes into one registered stream.
// A single output register is refilled whenever it is empty or being
// drained, so with the sink always ready the stream runs at one word per
// cycle. out_sel tags each word with its source lane for a downstream
// demux. xfer_cnt counts sink handshakes and wraps.
module mux4x1_rr_merge
    import mux4x1_rr_merge_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
)(
    input logic               clk,
    input logic               rst_n,
    mux4x1_rr_merge_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    ch_idx_t           out_sel_q,   out_sel_d;
    ch_idx_t           ptr_q,       ptr_d;
    logic [CNT_W-1:0]  xfer_cnt_q,  xfer_cnt_d;

    ch_mask_t          arb_gnt;
    ch_idx_t           arb_idx;
    logic              arb_any;
    logic              arb_en;
    logic              load_en;
    logic              in_hs;
    logic              out_hs;
    logic [DATA_W-1:0] sel_data;

    // Output register can take a new word when empty or emptying this cycle.
    // Reset blocks any acceptance so nothing is lost while rst_n is low.
    assign load_en = !out_valid_q || bus.out_ready;
    assign arb_en  = load_en && rst_n;
    assign in_hs   = arb_en && arb_any;
    assign out_hs  = out_valid_q && bus.out_ready;

    rr_arbiter4 u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Steer the winning lane's word toward the output register.
    always_comb begin
        sel_data = bus.in_data0;
        case (arb_idx)
            CH0:     sel_data = bus.in_data0;
            CH1:     sel_data = bus.in_data1;
            CH2:     sel_data = bus.in_data2;
            CH3:     sel_data = bus.in_data3;
            default: sel_data = bus.in_data0;
        endcase
    end

    // Next-state: load on input handshake, empty when draining with no
    // requester, otherwise hold; count every completed sink transfer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        xfer_cnt_d  = xfer_cnt_q;

        if (out_hs) begin
            xfer_cnt_d = xfer_cnt_q + CNT_ONE;
        end

        if (in_hs) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = arb_idx;
            ptr_d       = next_ptr(arb_idx);
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= CH0;
            ptr_q       <= CH0;
            xfer_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign bus.in_ready  = arb_gnt;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.xfer_cnt  = xfer_cnt_q;

endmodule
